// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a
// 4:1 data mux driven from the registered owner index.
// Optional macro RR_MUX_ARBITER_TIMEOUT_EN adds an 8-bit hold counter that
// forces the owner to release after MAX_HOLD cycles when someone else waits.
module rr_mux_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       in0,
   input  logic       in1,
   input  logic       in2,
   input  logic       in3,
   output logic [3:0] grant,
   output logic       valid,
   output logic       address0,
   output logic       address1,
   output logic       out
);

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   // Elaboration-time guard on the hold limit.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD out of range 2..255");
   end

   state_e     state_q, state_d;
   logic [1:0] last_q, last_d;
   logic [3:0] grant_q, grant_d;
   logic [1:0] addr_q, addr_d;

`ifdef RR_MUX_ARBITER_TIMEOUT_EN
   localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);
   logic [7:0] cnt_q, cnt_d;
`endif

   // Returns {found, index} of the first set bit of cand, searching base+1 .. base+4.
   function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] base);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 1; k <= 4; k++) begin
         idx = base + 2'(k);
         if (!res[2] && cand[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   logic [3:0] others;
   logic [2:0] hit_all;
   logic [2:0] hit_oth;
   logic       timeout_hit;
   logic       release_own;

   // Next-state: idle search, hold, handoff or forced release.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      addr_d      = addr_q;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_hit = (cnt_q == HoldLast);
`else
      timeout_hit = 1'b0;
`endif
      others      = req & ~grant_q;
      hit_all     = rr_pick(req, last_q);
      hit_oth     = rr_pick(others, last_q);
      release_own = ~(|(req & grant_q)) | (timeout_hit & (|others));

      case (state_q)
         StIdle: begin
            if (hit_all[2]) begin
               state_d = StOwn;
               grant_d = 4'b0001 << hit_all[1:0];
               addr_d  = hit_all[1:0];
               last_d  = hit_all[1:0];
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
               cnt_d   = 8'd0;
`endif
            end
         end
         StOwn: begin
            if (release_own) begin
               if (hit_oth[2]) begin
                  // Direct handoff, no idle bubble.
                  grant_d = 4'b0001 << hit_oth[1:0];
                  addr_d  = hit_oth[1:0];
                  last_d  = hit_oth[1:0];
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
                  cnt_d   = 8'd0;
`endif
               end else begin
                  state_d = StIdle;
                  grant_d = 4'b0000;
                  addr_d  = 2'b00;
               end
            end else begin
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
               // Limit reached with nobody waiting: keep the grant, restart the count.
               cnt_d = timeout_hit ? 8'd0 : cnt_q + 8'd1;
`endif
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = 4'b0000;
            addr_d  = 2'b00;
         end
      endcase
   end

   // State registers; last resets to 3 so the first grant favours index 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         last_q  <= 2'd3;
         grant_q <= 4'b0000;
         addr_q  <= 2'b00;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
         cnt_q   <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign grant    = grant_q;
   assign valid    = |grant_q;
   assign address0 = addr_q[0];
   assign address1 = addr_q[1];

   // Data mux from the registered select, gated when nobody owns the bus.
   always_comb begin
      out = 1'b0;
      case (addr_q)
         2'd0:    out = in0;
         2'd1:    out = in1;
         2'd2:    out = in2;
         default: out = in3;
      endcase
      out = out & valid;
   end

endmodule
